// File: rtl/apb_mux_n.sv
// Registered APB decoder/mux: one CPU master to NSLV slaves over a base/mask map.
// Unmapped addresses get an error response, and a watchdog ends accesses that are never acked.
module apb_mux_n #(
  parameter int                   NSLV       = 9,
  parameter int                   AW         = 32,
  parameter int                   DW         = 32,
  parameter logic [NSLV*AW-1:0]   SLV_BASE   = '0,
  parameter logic [NSLV*AW-1:0]   SLV_MASK   = '0,
  parameter int                   TIMEOUT    = 255,
  parameter bit                   STRIP_BASE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apb_psel_cpu,
  input  logic              apb_enab_cpu,
  input  logic              apb_rw_cpu,
  input  logic [AW-1:0]     apb_addr_cpu,
  input  logic [DW-1:0]     apb_datai_cpu,
  output logic [DW-1:0]     apb_datao_cpu,
  output logic              apb_ack_cpu,
  output logic              apb_err_cpu,
  output logic [NSLV-1:0]   apbs_psel,
  output logic [NSLV-1:0]   apbs_enab,
  output logic              apbs_rw,
  output logic [AW-1:0]     apbs_addr,
  output logic [DW-1:0]     apbs_datai,
  input  logic [NSLV*DW-1:0] apbs_datao,
  input  logic [NSLV-1:0]   apbs_ack
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   datai_q, datai_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic [NSLV-1:0] enab_q, enab_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   datao_q, datao_d;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [AW-1:0]   dec_mask;
  logic [DW-1:0]   slv_rdata;
  logic            slv_ack;
  logic            accept;

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((apb_addr_cpu & ~SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  assign dec_mask  = SLV_MASK[dec_idx*AW +: AW];
  assign slv_rdata = apbs_datao[idx_q*DW +: DW];
  assign slv_ack   = apbs_ack[idx_q];
  assign accept    = apb_psel_cpu & ~apb_enab_cpu;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    datai_d = datai_q;
    psel_d  = psel_q;
    enab_d  = enab_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    datao_d = datao_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rw_d    = apb_rw_cpu;
          datai_d = apb_datai_cpu;
          if (dec_hit) begin
            idx_d   = dec_idx;
            addr_d  = STRIP_BASE ? (apb_addr_cpu & dec_mask)
                                 : apb_addr_cpu;
            psel_d  = NSLV'(1) << dec_idx;
            state_d = S_SETUP;
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            datao_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: begin
        enab_d  = psel_q;
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (slv_ack) begin
          ack_d   = 1'b1;
          datao_d = rw_q ? '0 : slv_rdata;
          psel_d  = '0;
          enab_d  = '0;
          cnt_d   = '0;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          datao_d = '0;
          psel_d  = '0;
          enab_d  = '0;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        idx_d   = '0;
        rw_d    = 1'b0;
        addr_d  = '0;
        datai_d = '0;
        psel_d  = '0;
        enab_d  = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      datai_q <= '0;
      psel_q  <= '0;
      enab_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      datao_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      datai_q <= datai_d;
      psel_q  <= psel_d;
      enab_q  <= enab_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      datao_q <= datao_d;
    end
  end

  assign apb_datao_cpu = datao_q;
  assign apb_ack_cpu   = ack_q;
  assign apb_err_cpu   = err_q;
  assign apbs_psel     = psel_q;
  assign apbs_enab     = enab_q;
  assign apbs_rw       = rw_q;
  assign apbs_addr     = addr_q;
  assign apbs_datai    = datai_q;

endmodule
